// File: rtl/frv_pipeline_fwd_chain.sv
// Purpose : in-order pipeline chain of DEPTH stages with bubble collapse and
//           per-port GPR forwarding (youngest matching stage wins).
// Latency : DEPTH cycles from input acceptance to output when never stalled.
// Backpr. : s_busy asserts only when stage 0 is full and cannot shift; m_busy
//           freezes the oldest stage, and bubbles collapse toward it.
// Ports   : g_clk/g_reset (sync, active-high); s_* input beat; m_* oldest
//           stage; flush drops all stages; rp_* forwarding ports; occupancy.
module frv_pipeline_fwd_chain #(
  parameter  int DEPTH = 3,
  parameter  int DW    = 32,
  parameter  int NRP   = 2,
  localparam int OW    = $clog2(DEPTH + 1)
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              s_valid,
  output logic              s_busy,
  input  logic [4:0]        s_rd,
  input  logic              s_wen,
  input  logic              s_fwd_ok,
  input  logic [DW-1:0]     s_wdata,
  input  logic [DW-1:0]     s_payload,
  output logic              m_valid,
  input  logic              m_busy,
  output logic [4:0]        m_rd,
  output logic              m_wen,
  output logic [DW-1:0]     m_wdata,
  output logic [DW-1:0]     m_payload,
  input  logic              flush,
  input  logic [NRP*5-1:0]  rp_rs,
  output logic [NRP-1:0]    rp_hit,
  output logic [NRP-1:0]    rp_stall,
  output logic [NRP*DW-1:0] rp_data,
  output logic [OW-1:0]     occupancy
);

  // Stage storage; index 0 is the youngest, DEPTH-1 the oldest.
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_wen;
  logic [DEPTH-1:0] r_fok;
  logic [4:0]       r_rd      [DEPTH];
  logic [DW-1:0]    r_wdata   [DEPTH];
  logic [DW-1:0]    r_payload [DEPTH];
  logic [OW-1:0]    r_occ;

  logic [DEPTH-1:0] w_adv;      // stage i hands its content to i+1 this cycle
  logic [DEPTH-1:0] w_vld_nxt;
  logic [DEPTH-1:0] w_load;     // stage i captures a valid beat this cycle
  logic [OW-1:0]    w_occ_nxt;

  // Advance chain: resolved from the oldest stage back, so an empty slot
  // anywhere downstream lets everything younger than it move up.
  always_comb begin
    w_adv = '0;
    w_adv[DEPTH-1] = r_vld[DEPTH-1] & ~m_busy;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_adv[i] = ~r_vld[i+1] | w_adv[i+1];
    end
  end

  // Next valid bits and data-capture enables. Flush wins over any transfer;
  // fields only move when a real beat arrives so idle stages keep their data.
  always_comb begin
    w_vld_nxt = '0;
    w_load    = '0;
    if (!flush) begin
      w_vld_nxt[0] = w_adv[0] ? s_valid : r_vld[0];
      w_load[0]    = w_adv[0] & s_valid;
      for (int i = 1; i < DEPTH; i++) begin
        w_vld_nxt[i] = w_adv[i-1] ? r_vld[i-1] : r_vld[i];
        w_load[i]    = w_adv[i-1] & r_vld[i-1];
      end
    end
  end

  // Occupancy is registered from the same next-state vector as the valid
  // bits, so the two can never disagree.
  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ_nxt = w_occ_nxt + OW'(w_vld_nxt[i]);
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_vld <= '0;
      r_wen <= '0;
      r_fok <= '0;
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]      <= '0;
        r_wdata[i]   <= '0;
        r_payload[i] <= '0;
      end
    end else begin
      r_vld <= w_vld_nxt;
      r_occ <= w_occ_nxt;
      if (w_load[0]) begin
        r_rd[0]      <= s_rd;
        r_wen[0]     <= s_wen;
        r_fok[0]     <= s_fwd_ok;
        r_wdata[0]   <= s_wdata;
        r_payload[0] <= s_payload;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_load[i]) begin
          r_rd[i]      <= r_rd[i-1];
          r_wen[i]     <= r_wen[i-1];
          r_fok[i]     <= r_fok[i-1];
          r_wdata[i]   <= r_wdata[i-1];
          r_payload[i] <= r_payload[i-1];
        end
      end
    end
  end

  assign s_busy    = r_vld[0] & ~w_adv[0];
  assign m_valid   = r_vld[DEPTH-1];
  assign m_rd      = r_rd[DEPTH-1];
  assign m_wen     = r_wen[DEPTH-1];
  assign m_wdata   = r_wdata[DEPTH-1];
  assign m_payload = r_payload[DEPTH-1];
  assign occupancy = r_occ;

  // Forwarding: scan youngest to oldest and latch the first match. Only
  // registered stages are visible; the beat on s_* this cycle is not.
  logic [4:0]    w_rs;
  logic          w_found;
  logic          w_fok;
  logic [DW-1:0] w_wd;

  always_comb begin
    rp_hit   = '0;
    rp_stall = '0;
    rp_data  = '0;
    w_rs     = '0;
    w_found  = 1'b0;
    w_fok    = 1'b0;
    w_wd     = '0;
    for (int k = 0; k < NRP; k++) begin
      w_rs    = rp_rs[k*5 +: 5];
      w_found = 1'b0;
      w_fok   = 1'b0;
      w_wd    = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!w_found && r_vld[i] && r_wen[i] && (r_rd[i] == w_rs) && (w_rs != '0)) begin
          w_found = 1'b1;
          w_fok   = r_fok[i];
          w_wd    = r_wdata[i];
        end
      end
      rp_hit[k]   = w_found;
      // A winner whose result is not final must stall the reader rather than
      // let it fall through to an older, stale match.
      rp_stall[k] = w_found & ~w_fok;
      rp_data[k*DW +: DW] = (w_found && w_fok) ? w_wd : '0;
    end
  end

endmodule

// File: tb/tb_frv_pipeline_fwd_chain.sv
module tb_frv_pipeline_fwd_chain;
  localparam int DEPTH = 3;
  localparam int DW    = 32;
  localparam int NRP   = 2;
  localparam int OW    = $clog2(DEPTH + 1);

  logic              g_clk;
  logic              g_reset;
  logic              s_valid;
  logic              s_busy;
  logic [4:0]        s_rd;
  logic              s_wen;
  logic              s_fwd_ok;
  logic [DW-1:0]     s_wdata;
  logic [DW-1:0]     s_payload;
  logic              m_valid;
  logic              m_busy;
  logic [4:0]        m_rd;
  logic              m_wen;
  logic [DW-1:0]     m_wdata;
  logic [DW-1:0]     m_payload;
  logic              flush;
  logic [NRP*5-1:0]  rp_rs;
  logic [NRP-1:0]    rp_hit;
  logic [NRP-1:0]    rp_stall;
  logic [NRP*DW-1:0] rp_data;
  logic [OW-1:0]     occupancy;

  frv_pipeline_fwd_chain #(.DEPTH(DEPTH), .DW(DW), .NRP(NRP)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .s_valid   (s_valid),
    .s_busy    (s_busy),
    .s_rd      (s_rd),
    .s_wen     (s_wen),
    .s_fwd_ok  (s_fwd_ok),
    .s_wdata   (s_wdata),
    .s_payload (s_payload),
    .m_valid   (m_valid),
    .m_busy    (m_busy),
    .m_rd      (m_rd),
    .m_wen     (m_wen),
    .m_wdata   (m_wdata),
    .m_payload (m_payload),
    .flush     (flush),
    .rp_rs     (rp_rs),
    .rp_hit    (rp_hit),
    .rp_stall  (rp_stall),
    .rp_data   (rp_data),
    .occupancy (occupancy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [DW-1:0] pl;
    logic [4:0]    rd;
    logic          wen;
    logic [DW-1:0] wd;
    int            cyc;
  } beat_t;

  beat_t sb[$];
  beat_t mon_b;
  int    n_chk  = 0;
  int    n_pass = 0;
  int    cyc    = 0;
  bit    lat_on = 1'b0;
  logic [DW-1:0] pls [5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge g_clk) cyc <= cyc + 1;

  // Scoreboard: push accepted beats, pop and compare on output transfers.
  always @(negedge g_clk) begin
    if (g_reset) begin
      sb.delete();
    end else begin
      if (m_valid && !m_busy) begin
        if (sb.size() == 0) begin
          chk("sb_pop_empty", 64'(sb.size()), 64'd1);
        end else begin
          mon_b = sb.pop_front();
          chk("out_payload", m_payload, mon_b.pl);
          chk("out_rd", m_rd, mon_b.rd);
          chk("out_wen", m_wen, mon_b.wen);
          chk("out_wdata", m_wdata, mon_b.wd);
          if (lat_on) chk("latency", 64'(cyc - mon_b.cyc), 64'(DEPTH));
        end
      end
      if (flush) sb.delete();
      else if (s_valid && !s_busy)
        sb.push_back('{s_payload, s_rd, s_wen, s_wdata, cyc});
    end
  end

  task automatic drive(input logic v, input logic [4:0] rd, input logic fok,
                       input logic [DW-1:0] wd, input logic [DW-1:0] pl, input logic busy);
    @(posedge g_clk);
    #1;
    s_valid   = v;
    s_rd      = rd;
    s_wen     = 1'b1;
    s_fwd_ok  = fok;
    s_wdata   = wd;
    s_payload = pl;
    m_busy    = busy;
  endtask

  task automatic idle(input logic busy);
    drive(1'b0, 5'd0, 1'b0, '0, '0, busy);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    idle(1'b0);
    @(negedge g_clk);
    while ((occupancy != 0 || sb.size() != 0) && n < 50) begin
      @(negedge g_clk);
      n++;
    end
    chk({tag, "_occ"}, occupancy, 0);
    chk({tag, "_sb"}, 64'(sb.size()), 0);
  endtask

  task automatic do_flush(input logic v, input logic busy);
    @(posedge g_clk);
    #1;
    flush     = 1'b1;
    s_valid   = v;
    s_rd      = 5'd5;
    s_payload = 32'h99;
    m_busy    = busy;
    @(posedge g_clk);
    #1;
    flush   = 1'b0;
    s_valid = 1'b0;
  endtask

  // Stage 2: rd5/0x11, stage 1: rd7/0x33, stage 0: rd5/0x22 with fwd_ok=fok0.
  task automatic fill_fwd(input logic fok0);
    drive(1'b1, 5'd5, 1'b1, 32'h11, 32'h31, 1'b1);
    drive(1'b1, 5'd7, 1'b1, 32'h33, 32'h32, 1'b1);
    drive(1'b1, 5'd5, fok0, 32'h22, 32'h33, 1'b1);
    idle(1'b1);
  endtask

  initial begin
    pls       = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
    g_reset   = 1'b1;
    s_valid   = 1'b0;
    s_rd      = '0;
    s_wen     = 1'b0;
    s_fwd_ok  = 1'b0;
    s_wdata   = '0;
    s_payload = '0;
    m_busy    = 1'b0;
    flush     = 1'b0;
    rp_rs     = {5'd3, 5'd5};
    repeat (2) @(posedge g_clk);
    #1 g_reset = 1'b0;
    @(negedge g_clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_busy", s_busy, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_m_rd", m_rd, 0);
    chk("rst_m_wen", m_wen, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_payload", m_payload, 0);
    chk("rst_rp_hit", rp_hit, 0);
    chk("rst_rp_stall", rp_stall, 0);
    chk("rst_rp_data", rp_data, 0);

    // Streaming with no backpressure; latency checked by the scoreboard.
    lat_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(i + 1), 1'b1, 32'(100 + i), pls[i], 1'b0);
      @(negedge g_clk);
      chk("strm_s_busy", s_busy, 0);
      chk("strm_occ", occupancy, (i < 3) ? i : 3);
    end
    drain("strm_drain");
    lat_on = 1'b0;

    // Backpressure: fourth beat refused, output held while stalled.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, 1'b1, 32'(i + 1), 32'(i + 1), 1'b1);
      @(negedge g_clk);
      chk("bp_s_busy", s_busy, (i == 3) ? 1 : 0);
    end
    chk("bp_occ", occupancy, 3);
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      @(negedge g_clk);
      chk("bp_hold_valid", m_valid, 1);
      chk("bp_hold_payload", m_payload, 32'h1);
      chk("bp_hold_occ", occupancy, 3);
    end
    drain("bp_drain");

    // Bubble collapse while stalled.
    drive(1'b1, 5'd2, 1'b1, 32'h21, 32'h21, 1'b1);
    idle(1'b1);
    drive(1'b1, 5'd2, 1'b1, 32'h22, 32'h22, 1'b1);
    idle(1'b1);
    idle(1'b1);
    @(negedge g_clk);
    chk("bub_occ", occupancy, 2);
    chk("bub_m_payload", m_payload, 32'h21);
    chk("bub_s_busy", s_busy, 0);
    drain("bub_drain");

    // Forwarding: youngest match wins, rs=0 never hits.
    fill_fwd(1'b1);
    rp_rs = {5'd0, 5'd5};
    @(negedge g_clk);
    chk("fwd_occ", occupancy, 3);
    chk("fwd_full_s_busy", s_busy, 1);
    chk("fwd_hit0", rp_hit[0], 1);
    chk("fwd_data0", rp_data[DW-1:0], 32'h22);
    chk("fwd_stall0", rp_stall[0], 0);
    chk("fwd_hit1_rs0", rp_hit[1], 0);
    chk("fwd_stall1_rs0", rp_stall[1], 0);
    chk("fwd_data1_rs0", rp_data[2*DW-1:DW], 0);
    @(posedge g_clk);
    #1 rp_rs = {5'd7, 5'd9};
    @(negedge g_clk);
    chk("fwd_hit1_mid", rp_hit[1], 1);
    chk("fwd_data1_mid", rp_data[2*DW-1:DW], 32'h33);
    chk("fwd_hit0_miss", rp_hit[0], 0);
    do_flush(1'b0, 1'b1);
    @(negedge g_clk);
    chk("fl1_occ", occupancy, 0);

    fill_fwd(1'b0);
    rp_rs = {5'd0, 5'd5};
    @(negedge g_clk);
    chk("fwd_nok_hit0", rp_hit[0], 1);
    chk("fwd_nok_stall0", rp_stall[0], 1);
    chk("fwd_nok_data0", rp_data[DW-1:0], 0);

    // Flush on a full chain with a simultaneous input and output transfer.
    do_flush(1'b1, 1'b0);
    @(negedge g_clk);
    chk("fl2_occ", occupancy, 0);
    chk("fl2_m_valid", m_valid, 0);
    chk("fl2_rp_hit", rp_hit, 0);
    chk("fl2_s_busy", s_busy, 0);

    // Reset pulsed mid-stream.
    rp_rs = {5'd4, 5'd4};
    for (int i = 0; i < 3; i++) drive(1'b1, 5'd4, 1'b1, 32'(32'h40 + i), 32'(32'h50 + i), 1'b0);
    @(posedge g_clk);
    #1;
    g_reset   = 1'b1;
    s_payload = 32'h60;
    @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    s_valid = 1'b0;
    @(negedge g_clk);
    chk("mrst_m_valid", m_valid, 0);
    chk("mrst_m_payload", m_payload, 0);
    chk("mrst_m_rd", m_rd, 0);
    chk("mrst_m_wen", m_wen, 0);
    chk("mrst_m_wdata", m_wdata, 0);
    chk("mrst_occ", occupancy, 0);
    chk("mrst_s_busy", s_busy, 0);
    chk("mrst_rp_hit", rp_hit, 0);
    chk("mrst_rp_stall", rp_stall, 0);
    chk("mrst_rp_data", rp_data, 0);

    drive(1'b1, 5'd6, 1'b1, 32'h77, 32'h78, 1'b0);
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
